// File: rtl/alu_decode_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_decode_stage_if
//  Description : Bundle of handshake, flag and control-word signals between
//                instruction fetch, the decode stage and the ALU datapath.
//                master : upstream/downstream environment (drives the
//                         instruction stream, flags, switches, out_ready, flush)
//                slave  : the decode stage (drives in_ready and the registered
//                         control word)
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_decode_stage_if #(
    parameter int DATA_WIDTH    = 16,
    parameter int REG_SEL_WIDTH = 4
);
    localparam int FLAG_W = 2 ** REG_SEL_WIDTH;

    // upstream handshake
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [15:0]              instruction;

    // per-register status and board inputs, sampled on accept
    logic [FLAG_W-1:0]        zeroflag;
    logic [FLAG_W-1:0]        signflag;
    logic [FLAG_W-1:0]        overflow;
    logic [FLAG_W-1:0]        errorbit;
    logic [DATA_WIDTH-1:0]    switches;

    // downstream control word
    logic                     out_valid;
    logic                     out_ready;
    logic [3:0]               alu_op;
    logic [REG_SEL_WIDTH-1:0] alu_a_select;
    logic [REG_SEL_WIDTH-1:0] alu_b_select;
    logic [REG_SEL_WIDTH-1:0] alu_out_select;
    logic                     alu_b_source;
    logic [DATA_WIDTH-1:0]    alu_b_altern;
    logic [1:0]               alu_load_src;
    logic [DATA_WIDTH-1:0]    pc_advance;
    logic                     illegal;

    modport master (
        output flush, in_valid, instruction,
        output zeroflag, signflag, overflow, errorbit, switches,
        output out_ready,
        input  in_ready, out_valid, alu_op, alu_a_select, alu_b_select,
        input  alu_out_select, alu_b_source, alu_b_altern, alu_load_src,
        input  pc_advance, illegal
    );

    modport slave (
        input  flush, in_valid, instruction,
        input  zeroflag, signflag, overflow, errorbit, switches,
        input  out_ready,
        output in_ready, out_valid, alu_op, alu_a_select, alu_b_select,
        output alu_out_select, alu_b_source, alu_b_altern, alu_load_src,
        output pc_advance, illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_decode_stage
//  Description : Registered instruction-decode stage. Accepts one 16-bit
//                instruction per valid/ready handshake and presents an ALU
//                control word plus PC advance one cycle later.
//  Ports       : clock  - clock
//                reset  - asynchronous, active-high reset
//                bus    - alu_decode_stage_if.slave (handshake, flags,
//                         switches, flush, registered control word, illegal)
//  Options     : ALU_DECODE_WIDE_IMM_EN - when defined, opcode 0xF starts a
//                two-word wide-literal load; otherwise 0xF is an illegal noop.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_decode_stage #(
    parameter int DATA_WIDTH    = 16,
    parameter int REG_SEL_WIDTH = 4
) (
    input  wire logic          clock,
    input  wire logic          reset,
    alu_decode_stage_if.slave  bus
);

    localparam logic [1:0] LOAD_NONE = 2'b00;
    localparam logic [1:0] LOAD_ALU  = 2'b01;
    localparam logic [1:0] LOAD_SW   = 2'b10;

    localparam logic [3:0] OP_NULL   = 4'h0;
    localparam logic [3:0] OP_INC    = 4'hC;
    localparam logic [3:0] OP_UNARY  = 4'hD;
    localparam logic [3:0] OP_JUMP   = 4'hE;
    localparam logic [3:0] OP_WIDE   = 4'hF;

    localparam logic [3:0] ALU_PASS_B = 4'h0;
    localparam logic [3:0] ALU_ADD    = 4'h1;

    localparam logic [DATA_WIDTH-1:0] PC_ONE = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] PC_TWO = DATA_WIDTH'(2);

    typedef struct packed {
        logic [3:0]               op;
        logic [REG_SEL_WIDTH-1:0] a;
        logic [REG_SEL_WIDTH-1:0] b;
        logic [REG_SEL_WIDTH-1:0] o;
        logic                     bsrc;
        logic [DATA_WIDTH-1:0]    balt;
        logic [1:0]               load;
        logic [DATA_WIDTH-1:0]    pc;
    } ctrl_t;

    // ------------------------------------------------------------------
    // Field extraction (register selects keep only the low bits)
    // ------------------------------------------------------------------
    logic [3:0]               w_opcode;
    logic [REG_SEL_WIDTH-1:0] w_fld_a;
    logic [REG_SEL_WIDTH-1:0] w_fld_b;
    logic [REG_SEL_WIDTH-1:0] w_fld_o;
    logic [DATA_WIDTH-1:0]    w_inc_imm;
    logic [DATA_WIDTH-1:0]    w_jmp_off;

    assign w_opcode  = bus.instruction[15:12];
    assign w_fld_a   = bus.instruction[8 +: REG_SEL_WIDTH];
    assign w_fld_b   = bus.instruction[4 +: REG_SEL_WIDTH];
    assign w_fld_o   = bus.instruction[0 +: REG_SEL_WIDTH];
    assign w_inc_imm = DATA_WIDTH'($signed(bus.instruction[11:4]));
    assign w_jmp_off = DATA_WIDTH'($signed(bus.instruction[4:0]));

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic  out_valid_q, out_valid_d;
    logic  illegal_q,   illegal_d;
    ctrl_t ctrl_q,      ctrl_d;

    logic  w_in_ready;
    logic  w_accept;
    logic  w_emit;
    logic  w_lit_start;
    ctrl_t w_word;

    assign w_in_ready = !bus.flush && (!out_valid_q || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    // A wide-literal header is swallowed: it changes state but emits nothing.
    assign w_emit     = w_accept && !w_lit_start;

    // ------------------------------------------------------------------
    // Jump condition, evaluated on the flags present in the accept cycle
    // ------------------------------------------------------------------
    logic w_taken;

    always_comb begin : p_cond
        w_taken = 1'b0;
        case (bus.instruction[7:5])
            3'd0:    w_taken = 1'b1;
            3'd1:    w_taken = bus.zeroflag[w_fld_a];
            3'd2:    w_taken = !bus.zeroflag[w_fld_a];
            3'd3:    w_taken = bus.signflag[w_fld_a];
            3'd4:    w_taken = !bus.signflag[w_fld_a];
            3'd5:    w_taken = bus.overflow[w_fld_a];
            3'd6:    w_taken = bus.errorbit[w_fld_a];
            default: w_taken = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Single-word decode
    // ------------------------------------------------------------------
    ctrl_t w_dec;
    logic  w_dec_illegal;

    always_comb begin : p_decode
        w_dec         = '0;
        w_dec.pc      = PC_ONE;
        w_dec_illegal = 1'b0;
        case (w_opcode)
            OP_NULL: begin
                // Only sub-code 1 is a switch load; the sampled switch value
                // travels on the alternate-B bus for the datapath to store.
                if (bus.instruction[11:8] == 4'h1) begin
                    w_dec.o    = w_fld_o;
                    w_dec.balt = bus.switches;
                    w_dec.load = LOAD_SW;
                end
            end
            OP_INC: begin
                w_dec.op   = ALU_ADD;
                w_dec.a    = w_fld_o;
                w_dec.o    = w_fld_o;
                w_dec.bsrc = 1'b1;
                w_dec.balt = w_inc_imm;
                w_dec.load = LOAD_ALU;
            end
            OP_UNARY: begin
                w_dec.load = LOAD_NONE;
            end
            OP_JUMP: begin
                w_dec.pc = w_taken ? w_jmp_off : PC_ONE;
            end
            OP_WIDE: begin
`ifndef ALU_DECODE_WIDE_IMM_EN
                w_dec_illegal = 1'b1;
`endif
            end
            default: begin
                w_dec.op   = w_opcode;
                w_dec.a    = w_fld_a;
                w_dec.b    = w_fld_b;
                w_dec.o    = w_fld_o;
                w_dec.load = LOAD_ALU;
            end
        endcase
    end

`ifdef ALU_DECODE_WIDE_IMM_EN
    // ------------------------------------------------------------------
    // Wide-literal sequencer: IDLE -> LITERAL on a 0xF header, back to IDLE
    // on the following data word (or on flush/reset).
    // ------------------------------------------------------------------
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_LITERAL = 1'b1;

    logic [0:0]               state_q,   state_d;
    logic [REG_SEL_WIDTH-1:0] lit_dst_q, lit_dst_d;
    logic                     w_in_literal;

    always_ff @(posedge clock or posedge reset) begin : p_state_reg
        if (reset) begin
            state_q   <= ST_IDLE;
            lit_dst_q <= '0;
        end else begin
            state_q   <= state_d;
            lit_dst_q <= lit_dst_d;
        end
    end

    always_comb begin : p_next_state
        state_d   = state_q;
        lit_dst_d = lit_dst_q;
        if (bus.flush) begin
            state_d = ST_IDLE;
        end else if (w_accept) begin
            if (state_q == ST_LITERAL) begin
                state_d = ST_IDLE;
            end else if (w_opcode == OP_WIDE) begin
                state_d   = ST_LITERAL;
                lit_dst_d = w_fld_o;
            end
        end
    end

    always_comb begin : p_fsm_out
        w_in_literal = (state_q == ST_LITERAL);
        w_lit_start  = !w_in_literal && (w_opcode == OP_WIDE);
        if (w_in_literal) begin
            // Whole instruction word is raw literal data.
            w_word      = '0;
            w_word.op   = ALU_PASS_B;
            w_word.o    = lit_dst_q;
            w_word.bsrc = 1'b1;
            w_word.balt = DATA_WIDTH'($signed(bus.instruction));
            w_word.load = LOAD_ALU;
            w_word.pc   = PC_TWO;
        end else begin
            w_word = w_dec;
        end
    end
`else
    assign w_lit_start = 1'b0;
    assign w_word      = w_dec;
`endif

    // ------------------------------------------------------------------
    // Output pipeline register
    // ------------------------------------------------------------------
    always_comb begin : p_out_next
        ctrl_d      = w_emit ? w_word : ctrl_q;
        // Flush wins; otherwise a new word keeps valid high, and a consumed
        // word with nothing behind it drops valid.
        out_valid_d = bus.flush ? 1'b0
                                : (w_emit || (out_valid_q && !bus.out_ready));
        illegal_d   = illegal_q || (w_accept && w_dec_illegal);
    end

    always_ff @(posedge clock or posedge reset) begin : p_out_reg
        if (reset) begin
            ctrl_q      <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
        end
    end

    assign bus.in_ready       = w_in_ready;
    assign bus.out_valid      = out_valid_q;
    assign bus.alu_op         = ctrl_q.op;
    assign bus.alu_a_select   = ctrl_q.a;
    assign bus.alu_b_select   = ctrl_q.b;
    assign bus.alu_out_select = ctrl_q.o;
    assign bus.alu_b_source   = ctrl_q.bsrc;
    assign bus.alu_b_altern   = ctrl_q.balt;
    assign bus.alu_load_src   = ctrl_q.load;
    assign bus.pc_advance     = ctrl_q.pc;
    assign bus.illegal        = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_decode_stage
//  Description : Directed self-checking bench for alu_decode_stage. Stimulus
//                is driven 1 time unit after each rising edge and results are
//                sampled at the same point, after the registers settled.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_decode_stage;

    localparam int DW = 16;
    localparam int RW = 4;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    alu_decode_stage_if #(.DATA_WIDTH(DW), .REG_SEL_WIDTH(RW)) bus ();

    alu_decode_stage #(.DATA_WIDTH(DW), .REG_SEL_WIDTH(RW)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_word(input string tag, input logic [3:0] op,
                              input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] o, input logic bsrc,
                              input logic [15:0] balt, input logic [1:0] load,
                              input logic [15:0] pc);
        check_value({tag, ".valid"}, 32'(bus.out_valid),      32'd1);
        check_value({tag, ".op"},    32'(bus.alu_op),         32'(op));
        check_value({tag, ".a"},     32'(bus.alu_a_select),   32'(a));
        check_value({tag, ".b"},     32'(bus.alu_b_select),   32'(b));
        check_value({tag, ".out"},   32'(bus.alu_out_select), 32'(o));
        check_value({tag, ".bsrc"},  32'(bus.alu_b_source),   32'(bsrc));
        check_value({tag, ".balt"},  32'(bus.alu_b_altern),   32'(balt));
        check_value({tag, ".load"},  32'(bus.alu_load_src),   32'(load));
        check_value({tag, ".pc"},    32'(bus.pc_advance),     32'(pc));
    endtask

    logic [15:0] stream_words [4];

    initial begin
        stream_words[0] = 16'h1123;
        stream_words[1] = 16'h2234;
        stream_words[2] = 16'h3345;
        stream_words[3] = 16'h4456;

        reset           = 1'b1;
        bus.flush       = 1'b0;
        bus.in_valid    = 1'b0;
        bus.instruction = 16'h0000;
        bus.zeroflag    = '0;
        bus.signflag    = '0;
        bus.overflow    = '0;
        bus.errorbit    = '0;
        bus.switches    = '0;
        bus.out_ready   = 1'b1;
        step();
        step();

        // ---------------- reset state ----------------
        check_value("rst.valid",   32'(bus.out_valid),  32'd0);
        check_value("rst.illegal", 32'(bus.illegal),    32'd0);
        check_value("rst.pc",      32'(bus.pc_advance), 32'd0);
        check_value("rst.op",      32'(bus.alu_op),     32'd0);
        check_value("rst.ready",   32'(bus.in_ready),   32'd1);
        reset = 1'b0;

        // ---------------- binary ----------------
        bus.in_valid    = 1'b1;
        bus.instruction = 16'h3125;
        step();
        check_word("bin", 4'h3, 4'h1, 4'h2, 4'h5, 1'b0, 16'h0000, 2'b01, 16'h0001);

        // ---------------- increment by -1 ----------------
        bus.instruction = 16'hCFF7;
        step();
        check_word("inc", 4'h1, 4'h7, 4'h0, 4'h7, 1'b1, 16'hFFFF, 2'b01, 16'h0001);

        // ---------------- conditional jump on zero[2], offset -3 ----------------
        bus.instruction = 16'hE23D;
        bus.zeroflag    = 16'h0004;
        step();
        check_word("jz.t", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0000, 2'b00, 16'hFFFD);
        bus.zeroflag    = 16'h0000;
        step();
        check_word("jz.n", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0000, 2'b00, 16'h0001);

        // jump on sign[3], offset +5
        bus.instruction = 16'hE365;
        bus.signflag    = 16'h0008;
        step();
        check_value("js.pc", 32'(bus.pc_advance), 32'h0005);
        bus.signflag    = 16'h0000;

        // jump never
        bus.instruction = 16'hE0E5;
        step();
        check_value("jnever.pc", 32'(bus.pc_advance), 32'h0001);

        // ---------------- null class ----------------
        bus.instruction = 16'h0109;
        bus.switches    = 16'h5A5A;
        step();
        check_value("swld.out",  32'(bus.alu_out_select), 32'h9);
        check_value("swld.load", 32'(bus.alu_load_src),   32'h2);
        check_value("swld.pc",   32'(bus.pc_advance),     32'h1);
        bus.instruction = 16'h0209;
        step();
        check_word("noop", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0000, 2'b00, 16'h0001);

        // ---------------- backpressure then stream ----------------
        bus.out_ready   = 1'b0;
        bus.instruction = stream_words[0];
        #1;
        check_value("bp.ready0", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_value("bp.ready", 32'(bus.in_ready), 32'd0);
            check_word("bp.hold", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0000, 2'b00, 16'h0001);
        end
        bus.out_ready = 1'b1;
        #1;
        check_value("bp.release", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            check_value("stream.valid", 32'(bus.out_valid), 32'd1);
            check_value("stream.word",
                        32'({bus.alu_op, bus.alu_a_select, bus.alu_b_select,
                             bus.alu_out_select}),
                        32'(stream_words[i]));
            if (i < 3) bus.instruction = stream_words[i + 1];
            else       bus.in_valid    = 1'b0;
        end
        step();
        check_value("drain.valid", 32'(bus.out_valid), 32'd0);

        // ---------------- flush with valid output ----------------
        bus.in_valid    = 1'b1;
        bus.instruction = 16'h2345;
        step();
        check_value("fl.pre", 32'(bus.out_valid), 32'd1);
        bus.flush       = 1'b1;
        bus.instruction = 16'h5678;
        #1;
        check_value("fl.ready", 32'(bus.in_ready), 32'd0);
        step();
        check_value("fl.valid", 32'(bus.out_valid), 32'd0);
        bus.flush = 1'b0;
        step();
        check_word("fl.next", 4'h5, 4'h6, 4'h7, 4'h8, 1'b0, 16'h0000, 2'b01, 16'h0001);

`ifdef ALU_DECODE_WIDE_IMM_EN
        // ---------------- wide literal ----------------
        bus.instruction = 16'hF004;
        step();
        check_value("lit.hdr.valid", 32'(bus.out_valid), 32'd0);
        check_value("lit.illegal",   32'(bus.illegal),   32'd0);
        bus.instruction = 16'hBEEF;
        step();
        check_word("lit", 4'h0, 4'h0, 4'h0, 4'h4, 1'b1, 16'hBEEF, 2'b01, 16'h0002);

        // reset between header and data
        bus.instruction = 16'hF004;
        step();
        check_value("litrst.hdr", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        #1;
        check_value("litrst.pc", 32'(bus.pc_advance), 32'd0);
        step();
        reset           = 1'b0;
        bus.in_valid    = 1'b1;
        bus.instruction = 16'h3125;
        step();
        check_word("litrst.next", 4'h3, 4'h1, 4'h2, 4'h5, 1'b0, 16'h0000, 2'b01, 16'h0001);

        // flush while in LITERAL
        bus.instruction = 16'hF007;
        step();
        check_value("litfl.hdr", 32'(bus.out_valid), 32'd0);
        bus.flush = 1'b1;
        step();
        check_value("litfl.valid", 32'(bus.out_valid), 32'd0);
        bus.flush       = 1'b0;
        bus.instruction = 16'h3125;
        step();
        check_word("litfl.next", 4'h3, 4'h1, 4'h2, 4'h5, 1'b0, 16'h0000, 2'b01, 16'h0001);
`else
        // ---------------- 0xF is illegal ----------------
        bus.instruction = 16'hF004;
        step();
        check_word("ill", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0000, 2'b00, 16'h0001);
        check_value("ill.flag", 32'(bus.illegal), 32'd1);
        bus.instruction = 16'h3125;
        step();
        check_value("ill.sticky", 32'(bus.illegal), 32'd1);
        check_value("ill.next.op", 32'(bus.alu_op), 32'h3);
        bus.flush = 1'b1;
        step();
        check_value("ill.flush", 32'(bus.illegal), 32'd1);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        #1;
        check_value("ill.rst", 32'(bus.illegal), 32'd0);
        step();
        reset = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_decode_stage.md
# alu_decode_stage

Registered, parametrised instruction-decode stage for the flow control path. Accepts one 16-bit instruction word per valid/ready handshake, decodes null, binary, increment, unary and conditional-jump classes into an ALU control word plus a PC advance, and holds the result in an output pipeline register. A two-word wide-literal load is sequenced by an internal state machine. The block sits between instruction fetch and the ALU datapath.

## Interface
- `DATA_WIDTH`, 16: datapath width; width of flags, switches, immediates and `pc_advance` (≥ 8).
- `REG_SEL_WIDTH`, 4: register-select width (≤ 4, since instruction fields are 4 bits); flag vectors are `2**REG_SEL_WIDTH` wide.
- `clock  in  1  clock`; `reset  in  1  asynchronous, active-high`.
- `flush  in  1  drop the output register and pending literal state`.
- `in_valid  in  1`; `in_ready  out  1`; `instruction  in  16`.
- `zeroflag`, `signflag`, `overflow`, `errorbit  in  2**REG_SEL_WIDTH each  per-register flags`.
- `switches  in  DATA_WIDTH  board switch value`.
- `out_valid  out  1`; `out_ready  in  1`.
- `alu_op  out  4`; `alu_a_select`, `alu_b_select`, `alu_out_select  out  REG_SEL_WIDTH each`.
- `alu_b_source  out  1  1 = use alu_b_altern`; `alu_b_altern  out  DATA_WIDTH`.
- `alu_load_src  out  2  00 none, 01 ALU result, 10 switches`.
- `pc_advance  out  DATA_WIDTH  signed words added to PC`.
- `illegal  out  1  sticky illegal-opcode flag`.

## Operation
- Accept happens when `in_valid && in_ready`. `in_ready = !out_valid || out_ready`, and is forced to 0 while `flush` is high.
- Flags and switches are sampled in the accept cycle.
- Opcode is `instruction[15:12]`. Register fields are truncated to `REG_SEL_WIDTH` LSBs.
- **0x0 null:**
  - `[11:8]=1` gives a switch load into `[3:0]`, with `alu_load_src=10`.
  - Any other value is a noop with `alu_load_src=00`.
- **0x1–0xB binary:**
  - `alu_op` = opcode; a = `[11:8]`, b = `[7:4]`, out = `[3:0]`.
  - `alu_b_source=0`, `alu_load_src=01`.
- **0xC increment:**
  - `alu_op=1`; a = out = `[3:0]`.
  - `alu_b_altern` = sign-extend(`[11:4]`), `alu_b_source=1`, `alu_load_src=01`.
- **0xD unary:** noop, `alu_load_src=00`.
- **0xE jump:** register r = `[11:8]`, condition = `[7:5]`, offset = `[4:0]` signed.
  - Conditions: 0 always, 1 zero[r], 2 !zero[r], 3 sign[r], 4 !sign[r], 5 overflow[r], 6 errorbit[r], 7 never.
  - Taken: `pc_advance` = sign-extend(offset). Not taken: 1. `alu_load_src=00`.
- **0xF:** see Configuration.
- `pc_advance` = 1 for every class except taken jumps and the wide literal.
- Fields irrelevant to a class are driven 0. Every control word is deterministic.
- State machine, states IDLE and LITERAL:
  - IDLE to LITERAL: accept of an 0xF word (macro defined). The destination `[3:0]` is latched and no output word is produced.
  - LITERAL to IDLE: the next accepted word is taken as raw data. It emits `alu_op=0` (pass B), `alu_b_source=1`, `alu_b_altern` = literal (sign-extended if `DATA_WIDTH>16`, truncated if `<16`), out = latched register, `alu_load_src=01`, `pc_advance=2`.
- `flush`:
  - clears `out_valid` and returns to IDLE on the same edge;
  - does not clear `illegal`;
  - nothing is accepted in that cycle.

## Timing
- Latency is 1 cycle: a word accepted at edge n is presented with `out_valid=1` after edge n.
- Exception: an 0xF first word produces no output.
- Full throughput: one word per cycle when `out_ready=1`.
- Backpressure: while `out_valid && !out_ready`, all outputs are held stable and `in_ready=0`.
- Simultaneous consume and accept: the register is overwritten with the new word and `out_valid` stays 1.
- Consume with no accept: `out_valid` falls to 0.
- Reset (asynchronous, any time, including mid-LITERAL) sets:
  - `out_valid=0`, `illegal=0`, state IDLE;
  - all control outputs 0, including `pc_advance=0`.

## Configuration
- `ALU_DECODE_WIDE_IMM_EN` defined: 0xF is the two-word wide-literal load described above.
- Undefined:
  - 0xF decodes as a noop (`pc_advance=1`, `alu_load_src=00`) and sets `illegal`.
  - No LITERAL state exists; the FSM logic is compiled out.

## Test plan
- Reset, then accept 0x3125 with `out_ready=1`. Next cycle: `alu_op=3`, a=1, b=2, out=5, `alu_load_src=01`, `pc_advance=1`.
- Accept 0xCFF7 (increment by -1). Expect `alu_b_altern=0xFFFF`, a=out=7, `alu_b_source=1`. Then accept 0xE23D with `zeroflag[2]=1`: expect `pc_advance=0xFFFD`. Repeat with `zeroflag[2]=0`: expect `pc_advance=1`.
- Macro defined: accept 0xF004 then 0xBEEF.
  - After the first word, no `out_valid`.
  - After the second: out=4, `alu_b_altern=0xBEEF`, `pc_advance=2`.
  - Repeat with reset asserted between the words: the next word decodes normally.
- Hold `out_ready=0` for 3 cycles with `in_valid=1`. Expect `in_ready=0` and outputs unchanged. Release: a back-to-back stream of 4 words emerges in order with none lost or duplicated.
- Assert `flush` while `out_valid=1` and while in LITERAL. Expect `out_valid=0` and the next word decoded as a fresh instruction.
- Macro undefined: accept 0xF004. Expect `illegal=1`, a noop control word, and `illegal` sticky until reset.
